// File: rtl/height_history_writer.sv
// Stability filter that commits one height per person into a 10-deep shadow history, copied to hist_* on frame_start.
// Optional HEIGHT_AVG_EN: commit the truncated average of the stable run instead of its first sample.
module height_history_writer #(
  parameter int STABLE_COUNT = 4,
  parameter int TOLERANCE    = 2,
  parameter int MIN_HEIGHT   = 10,
  parameter int MAX_HEIGHT   = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [7:0] sample_cm,
  input  logic       frame_start,
  input  logic       clear,
  output logic [7:0] hist_0,
  output logic [7:0] hist_1,
  output logic [7:0] hist_2,
  output logic [7:0] hist_3,
  output logic [7:0] hist_4,
  output logic [7:0] hist_5,
  output logic [7:0] hist_6,
  output logic [7:0] hist_7,
  output logic [7:0] hist_8,
  output logic [7:0] hist_9,
  output logic [3:0] count,
  output logic       commit
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [7:0] MAX_H  = 8'(MAX_HEIGHT);
  localparam logic [7:0] MIN_H  = 8'(MIN_HEIGHT);
  localparam logic [3:0] STABLE = 4'(STABLE_COUNT);
`ifdef HEIGHT_AVG_EN
  localparam int SHIFT = $clog2(STABLE_COUNT);
  logic [11:0] sum, sum_nx;
`endif

  state_t     state, state_nx;
  logic [7:0] cand, cand_nx, locked, locked_nx;
  logic [3:0] cnt, cnt_nx, cnt_inc;
  logic       ready_q, take, do_commit;
  logic [7:0] s, commit_val;
  logic [7:0] shadow [10];
  logic [3:0] shadow_count;
  logic [7:0] hist_r [10];

  // Absolute difference widened to 9 bits so it can never wrap.
  function automatic logic out_of_tol(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return d > 9'(TOLERANCE);
  endfunction

  assign sample_ready = ready_q && !clear;
  assign take         = sample_valid && sample_ready;
  assign s            = (sample_cm > MAX_H) ? MAX_H : sample_cm;
  assign cnt_inc      = cnt + 4'd1;

  always_comb begin
    state_nx   = state;
    cand_nx    = cand;
    cnt_nx     = cnt;
    locked_nx  = locked;
    do_commit  = 1'b0;
    commit_val = cand;
`ifdef HEIGHT_AVG_EN
    sum_nx     = sum;
`endif
    if (clear) begin
      state_nx = IDLE;
    end else if (take) begin
      case (state)
        IDLE: begin
          if (s >= MIN_H) begin
            state_nx = TRACK;
            cand_nx  = s;
            cnt_nx   = 4'd1;
`ifdef HEIGHT_AVG_EN
            sum_nx   = {4'd0, s};
`endif
          end
        end
        TRACK: begin
          if (s < MIN_H) begin
            state_nx = IDLE;
          end else if (out_of_tol(s, cand)) begin
            cand_nx = s;
            cnt_nx  = 4'd1;
`ifdef HEIGHT_AVG_EN
            sum_nx  = {4'd0, s};
`endif
          end else begin
            cnt_nx = cnt_inc;
`ifdef HEIGHT_AVG_EN
            sum_nx     = sum + {4'd0, s};
            commit_val = 8'(sum_nx >> SHIFT);
`endif
            if (cnt_inc == STABLE) begin
              do_commit = 1'b1;
              state_nx  = LOCKED;
              locked_nx = commit_val;
            end
          end
        end
        LOCKED: begin
          if (s < MIN_H) begin
            state_nx = IDLE;
          end else if (out_of_tol(s, locked)) begin
            state_nx = TRACK;
            cand_nx  = s;
            cnt_nx   = 4'd1;
`ifdef HEIGHT_AVG_EN
            sum_nx   = {4'd0, s};
`endif
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cand         <= 8'd0;
      cnt          <= 4'd0;
      locked       <= 8'd0;
      ready_q      <= 1'b0;
      commit       <= 1'b0;
      shadow_count <= 4'd0;
      count        <= 4'd0;
      for (int i = 0; i < 10; i++) begin
        shadow[i] <= 8'd0;
        hist_r[i] <= 8'd0;
      end
`ifdef HEIGHT_AVG_EN
      sum          <= 12'd0;
`endif
    end else begin
      state   <= state_nx;
      cand    <= cand_nx;
      cnt     <= cnt_nx;
      locked  <= locked_nx;
      ready_q <= 1'b1;
      commit  <= do_commit;
`ifdef HEIGHT_AVG_EN
      sum     <= sum_nx;
`endif
      // Copy sees the pre-edge shadow, so a same-edge commit or clear shows up a frame later.
      if (frame_start) begin
        for (int i = 0; i < 10; i++) hist_r[i] <= shadow[i];
        count <= shadow_count;
      end
      if (clear) begin
        for (int i = 0; i < 10; i++) shadow[i] <= 8'd0;
        shadow_count <= 4'd0;
      end else if (do_commit) begin
        for (int i = 9; i > 0; i--) shadow[i] <= shadow[i-1];
        shadow[0] <= commit_val;
        if (shadow_count != 4'd10) shadow_count <= shadow_count + 4'd1;
      end
    end
  end

  assign hist_0 = hist_r[0];
  assign hist_1 = hist_r[1];
  assign hist_2 = hist_r[2];
  assign hist_3 = hist_r[3];
  assign hist_4 = hist_r[4];
  assign hist_5 = hist_r[5];
  assign hist_6 = hist_r[6];
  assign hist_7 = hist_r[7];
  assign hist_8 = hist_r[8];
  assign hist_9 = hist_r[9];

endmodule

// File: tb/tb_height_history_writer.sv
// Directed bench for height_history_writer: vector table for the filter, hand sequences for saturation, clamp, clear and reset.
module tb_height_history_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid, sample_ready, frame_start, clear, commit;
  logic [7:0] sample_cm;
  logic [7:0] h [10];
  logic [3:0] count;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  height_history_writer dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_cm(sample_cm),
    .frame_start(frame_start), .clear(clear),
    .hist_0(h[0]), .hist_1(h[1]), .hist_2(h[2]), .hist_3(h[3]), .hist_4(h[4]),
    .hist_5(h[5]), .hist_6(h[6]), .hist_7(h[7]), .hist_8(h[8]), .hist_9(h[9]),
    .count(count), .commit(commit)
  );

  typedef struct {
    logic       v;
    logic [7:0] cm;
    logic       fs;
    logic       clr;
    logic       e_commit;
    logic [7:0] e_h0;
    logic [7:0] e_h1;
    logic [3:0] e_count;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic v, input logic [7:0] cm, input logic fs, input logic clr,
                              input logic ec, input logic [7:0] h0, input logic [7:0] h1, input logic [3:0] c);
    vec_t r;
    r.v = v; r.cm = cm; r.fs = fs; r.clr = clr;
    r.e_commit = ec; r.e_h0 = h0; r.e_h1 = h1; r.e_count = c;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] cm, input logic fs, input logic clr);
    sample_valid = v; sample_cm = cm; frame_start = fs; clear = clr;
    @(posedge clk); #1;
    sample_valid = 1'b0; sample_cm = 8'd0; frame_start = 1'b0; clear = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 50, 0, 0, 0,  0,  0, 0);
    tbl[1]  = mk(1, 51, 0, 0, 0,  0,  0, 0);
    tbl[2]  = mk(1, 49, 0, 0, 0,  0,  0, 0);
    tbl[3]  = mk(1, 50, 0, 0, 1,  0,  0, 0);
    tbl[4]  = mk(0,  0, 1, 0, 0, 50,  0, 1);
    tbl[5]  = mk(1, 50, 0, 0, 0, 50,  0, 1);
    tbl[6]  = mk(1, 50, 0, 0, 0, 50,  0, 1);
    tbl[7]  = mk(1, 50, 0, 0, 0, 50,  0, 1);
    tbl[8]  = mk(1,  5, 0, 0, 0, 50,  0, 1);
    tbl[9]  = mk(1, 70, 0, 0, 0, 50,  0, 1);
    tbl[10] = mk(1, 70, 0, 0, 0, 50,  0, 1);
    tbl[11] = mk(1, 70, 0, 0, 0, 50,  0, 1);
    tbl[12] = mk(1, 70, 0, 0, 1, 50,  0, 1);
    tbl[13] = mk(0,  0, 1, 0, 0, 70, 50, 2);
    tbl[14] = mk(1, 60, 0, 0, 0, 70, 50, 2);
    tbl[15] = mk(1, 61, 0, 0, 0, 70, 50, 2);
    tbl[16] = mk(1, 65, 0, 0, 0, 70, 50, 2);
    tbl[17] = mk(1, 65, 0, 0, 0, 70, 50, 2);
    tbl[18] = mk(0, 65, 0, 0, 0, 70, 50, 2);
    tbl[19] = mk(1, 65, 0, 0, 0, 70, 50, 2);
    tbl[20] = mk(1, 65, 0, 0, 1, 70, 50, 2);
    tbl[21] = mk(0,  0, 1, 0, 0, 65, 70, 3);

    reset = 1'b1; sample_valid = 1'b0; sample_cm = 8'd0; frame_start = 1'b0; clear = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_ready", sample_ready, 0);
    chk("reset_count", count, 0);
    chk("reset_commit", commit, 0);
    chk("reset_h0", h[0], 0);
    reset = 1'b0;
    #1 chk("ready_before_edge", sample_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", sample_ready, 1);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].v, tbl[i].cm, tbl[i].fs, tbl[i].clr);
      chk($sformatf("vec%0d_commit", i), commit, tbl[i].e_commit);
      chk($sformatf("vec%0d_h0", i), h[0], tbl[i].e_h0);
      chk($sformatf("vec%0d_h1", i), h[1], tbl[i].e_h1);
      chk($sformatf("vec%0d_count", i), count, tbl[i].e_count);
    end

    // clear with frame_start: this frame still shows pre-clear shadow, next shows zeros
    step(0, 0, 1, 1);
    chk("clrfs_h0", h[0], 65);
    chk("clrfs_count", count, 3);
    step(0, 0, 1, 0);
    chk("clrfs_next_h0", h[0], 0);
    chk("clrfs_next_count", count, 0);

    // 12 heights separated by an absent sample; count saturates at 10
    for (int ht = 20; ht < 32; ht++) begin
      step(1, 5, 0, 0);
      for (int k = 0; k < 4; k++) step(1, 8'(ht), 0, 0);
      chk($sformatf("sat_commit_%0d", ht), commit, 1);
    end
    step(0, 0, 1, 0);
    for (int k = 0; k < 10; k++) chk($sformatf("sat_h%0d", k), h[k], 31 - k);
    chk("sat_count", count, 10);

    // clamp 200 -> 99, commit on the same edge as frame_start
    step(1, 5, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 200, 0, 0);
    step(1, 200, 1, 0);
    chk("clamp_commit", commit, 1);
    chk("clamp_same_frame_h0", h[0], 31);
    step(0, 0, 1, 0);
    chk("clamp_h0", h[0], 99);
    chk("clamp_h1", h[1], 31);
    chk("clamp_count", count, 10);

    // clear blocks a simultaneous sample
    sample_valid = 1'b1; sample_cm = 8'd40; clear = 1'b1;
    #1 chk("clear_ready", sample_ready, 0);
    @(posedge clk); #1;
    sample_valid = 1'b0; sample_cm = 8'd0; clear = 1'b0;
    step(0, 0, 1, 0);
    chk("clear_h0", h[0], 0);
    chk("clear_h9", h[9], 0);
    chk("clear_count", count, 0);
    for (int k = 0; k < 3; k++) step(1, 40, 0, 0);
    chk("clear_not_consumed", commit, 0);
    step(1, 40, 0, 0);
    chk("post_clear_commit", commit, 1);
    step(0, 0, 1, 0);
    chk("post_clear_h0", h[0], 40);
    chk("post_clear_count", count, 1);

    // async reset in TRACK
    step(1, 60, 0, 0);
    step(1, 60, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_h0", h[0], 0);
    chk("arst_count", count, 0);
    chk("arst_commit", commit, 0);
    chk("arst_ready", sample_ready, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("arst_ready_back", sample_ready, 1);
    step(0, 0, 1, 0);
    chk("arst_shadow_empty", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
